tlc_intersection: RTL and testbench

//  Two-road (main/side) traffic light controller, parametrised successor to the single-road TLC.

---
 rtl/tlc_intersection.sv | 170 +++++++++++++++++
 tb/tb_tlc_intersection.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/tlc_intersection.sv
// Two-road (main/side) traffic light controller with all-red clearance, pedestrian
// walk served during side green, and a flash (night) mode.
module tlc_intersection #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned T_MIN_G  = 8,
    parameter int unsigned T_YEL    = 3,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned T_SIDE_G = 6,
    parameter int unsigned T_FLASH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             side_req,
    input  logic             ped_req,
    input  logic             flash_en,
    output logic [1:0]       main_light,
    output logic [1:0]       side_light,
    output logic             walk,
    output logic [2:0]       ps_state,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        AR_A   = 3'd0,
        MAIN_G = 3'd1,
        MAIN_Y = 3'd2,
        AR_B   = 3'd3,
        SIDE_G = 3'd4,
        SIDE_Y = 3'd5,
        FLASH  = 3'd6
    } state_t;

    localparam logic [1:0] LAMP_RED  = 2'b00;
    localparam logic [1:0] LAMP_YEL  = 2'b01;
    localparam logic [1:0] LAMP_GRN  = 2'b11;
    localparam logic [1:0] LAMP_DARK = 2'b10;

    localparam logic [CNT_W-1:0] C_MIN_G_LAST  = CNT_W'(T_MIN_G - 1);
    localparam logic [CNT_W-1:0] C_YEL_LAST    = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] C_ALLRED_LAST = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] C_SIDE_G_LAST = CNT_W'(T_SIDE_G - 1);
    localparam logic [CNT_W-1:0] C_FLASH_LAST  = CNT_W'(T_FLASH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_ped_pend;
    logic             r_walk_on;
    logic             r_blink;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_ped_pend_nxt;
    logic             w_walk_on_nxt;
    logic             w_blink_nxt;
    logic             w_demand;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= AR_A;
            r_count    <= '0;
            r_ped_pend <= 1'b0;
            r_walk_on  <= 1'b0;
            r_blink    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_ped_pend <= w_ped_pend_nxt;
            r_walk_on  <= w_walk_on_nxt;
            r_blink    <= w_blink_nxt;
        end
    end

    // Only the latched request counts as demand; a same-edge ped_req is picked up next cycle.
    assign w_demand = side_req | r_ped_pend;

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count + 1'b1;
        w_ped_pend_nxt = r_ped_pend | ped_req;
        w_walk_on_nxt  = r_walk_on;
        w_blink_nxt    = r_blink;
        unique case (r_state)
            AR_A: begin
                if (r_count == C_ALLRED_LAST) begin
                    w_state_nxt = flash_en ? FLASH : MAIN_G;
                    w_count_nxt = '0;
                end
            end
            MAIN_G: begin
                if (r_count == C_MIN_G_LAST) begin
                    if (w_demand) begin
                        w_state_nxt = MAIN_Y;
                        w_count_nxt = '0;
                    end else begin
                        w_count_nxt = r_count;
                    end
                end
            end
            MAIN_Y: begin
                if (r_count == C_YEL_LAST) begin
                    w_state_nxt = AR_B;
                    w_count_nxt = '0;
                end
            end
            AR_B: begin
                if (r_count == C_ALLRED_LAST) begin
                    w_count_nxt = '0;
                    if (flash_en) begin
                        w_state_nxt = FLASH;
                    end else begin
                        w_state_nxt    = SIDE_G;
                        w_walk_on_nxt  = r_ped_pend | ped_req;
                        w_ped_pend_nxt = 1'b0;
                    end
                end
            end
            SIDE_G: begin
                if (r_count == C_SIDE_G_LAST) begin
                    w_state_nxt   = SIDE_Y;
                    w_count_nxt   = '0;
                    w_walk_on_nxt = 1'b0;
                end
            end
            SIDE_Y: begin
                if (r_count == C_YEL_LAST) begin
                    w_state_nxt = AR_A;
                    w_count_nxt = '0;
                end
            end
            FLASH: begin
                if (!flash_en) begin
                    w_state_nxt = AR_A;
                    w_count_nxt = '0;
                    w_blink_nxt = 1'b1;
                end else if (r_count == C_FLASH_LAST) begin
                    w_count_nxt = '0;
                    w_blink_nxt = ~r_blink;
                end
            end
            default: begin
                w_state_nxt = AR_A;
                w_count_nxt = '0;
            end
        endcase
    end

    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        unique case (r_state)
            MAIN_G: main_light = LAMP_GRN;
            MAIN_Y: main_light = LAMP_YEL;
            SIDE_G: side_light = LAMP_GRN;
            SIDE_Y: side_light = LAMP_YEL;
            FLASH: begin
                main_light = r_blink ? LAMP_YEL : LAMP_DARK;
                side_light = r_blink ? LAMP_RED : LAMP_DARK;
            end
            default: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

    assign walk     = r_walk_on && (r_state == SIDE_G);
    assign ps_state = r_state;
    assign count    = r_count;

endmodule

// File: tb/tb_tlc_intersection.sv
// Directed scoreboard bench for tlc_intersection: each cycle's expected state, count,
// lamps and walk are queued before the clock edge and compared at the following falling edge.
module tb_tlc_intersection;

    localparam int CW = 8;

    localparam logic [2:0] S_AR_A   = 3'd0;
    localparam logic [2:0] S_MAIN_G = 3'd1;
    localparam logic [2:0] S_MAIN_Y = 3'd2;
    localparam logic [2:0] S_AR_B   = 3'd3;
    localparam logic [2:0] S_SIDE_G = 3'd4;
    localparam logic [2:0] S_SIDE_Y = 3'd5;
    localparam logic [2:0] S_FLASH  = 3'd6;

    localparam logic [1:0] RED  = 2'b00;
    localparam logic [1:0] YEL  = 2'b01;
    localparam logic [1:0] GRN  = 2'b11;
    localparam logic [1:0] DARK = 2'b10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          side_req = 1'b0;
    logic          ped_req = 1'b0;
    logic          flash_en = 1'b0;
    logic [1:0]    main_light;
    logic [1:0]    side_light;
    logic          walk;
    logic [2:0]    ps_state;
    logic [CW-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] sb_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    tlc_intersection #(
        .CNT_W   (CW),
        .T_MIN_G (8),
        .T_YEL   (3),
        .T_ALLRED(2),
        .T_SIDE_G(6),
        .T_FLASH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .side_req  (side_req),
        .ped_req   (ped_req),
        .flash_en  (flash_en),
        .main_light(main_light),
        .side_light(side_light),
        .walk      (walk),
        .ps_state  (ps_state),
        .count     (count)
    );

    // Fixed lamp pattern of every non-flash state: {main, side}.
    function automatic logic [3:0] lamp(input logic [2:0] st);
        case (st)
            S_MAIN_G: return {GRN, RED};
            S_MAIN_Y: return {YEL, RED};
            S_SIDE_G: return {RED, GRN};
            S_SIDE_Y: return {RED, YEL};
            default:  return {RED, RED};
        endcase
    endfunction

    task automatic push_exp(input string tag, input logic [2:0] st, input int cnt,
                            input logic w, input logic [3:0] ms);
        sb_q.push_back({st, 8'(cnt), ms, w});
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        logic [15:0] exp_v;
        logic [15:0] obs_v;
        string       t;
        exp_v = sb_q.pop_front();
        t     = tag_q.pop_front();
        obs_v = {ps_state, count, main_light, side_light, walk};
        n_checks++;
        assert (obs_v === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed state/count/main/side/walk = %0d/%0d/%b/%b/%b, expected %0d/%0d/%b/%b/%b",
                   t, obs_v[15:13], obs_v[12:5], obs_v[4:3], obs_v[2:1], obs_v[0],
                   exp_v[15:13], exp_v[12:5], exp_v[4:3], exp_v[2:1], exp_v[0]);
        end
    endtask

    task automatic cycl(input string tag, input logic [2:0] st, input int cnt,
                        input logic w, input logic [3:0] ms);
        push_exp(tag, st, cnt, w, ms);
        @(negedge clk);
        pop_check();
    endtask

    task automatic cyc(input string tag, input logic [2:0] st, input int cnt, input logic w);
        cycl(tag, st, cnt, w, lamp(st));
    endtask

    task automatic run(input string tag, input logic [2:0] st, input int from, input int to,
                       input logic w);
        for (int i = from; i <= to; i++) cyc(tag, st, i, w);
    endtask

    // Full side service, starting from the edge that leaves MAIN_G; ped_req is high on
    // the edge that produces SIDE_G count ped_i (0 = the AR_B->SIDE_G edge).
    task automatic serve(input string tag, input logic w, input int ped_i);
        cyc(tag, S_MAIN_Y, 0, 1'b0);
        side_req = 1'b0;
        run(tag, S_MAIN_Y, 1, 2, 1'b0);
        run(tag, S_AR_B, 0, 1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ped_req = (i == ped_i);
            cyc(tag, S_SIDE_G, i, w);
        end
        ped_req = 1'b0;
        run(tag, S_SIDE_Y, 0, 2, 1'b0);
        run(tag, S_AR_A, 0, 1, 1'b0);
        cyc(tag, S_MAIN_G, 0, 1'b0);
    endtask

    initial begin
        #1;
        push_exp("reset", S_AR_A, 0, 1'b0, {RED, RED});
        pop_check();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        cyc("release_ar_a", S_AR_A, 1, 1'b0);
        cyc("main_g_entry", S_MAIN_G, 0, 1'b0);
        run("main_g_count", S_MAIN_G, 1, 7, 1'b0);
        repeat (101) cyc("main_g_rest", S_MAIN_G, 7, 1'b0);

        side_req = 1'b1;
        serve("side_from_rest", 1'b0, 99);

        run("main_g_pre_side", S_MAIN_G, 1, 3, 1'b0);
        side_req = 1'b1;
        run("main_g_min_hold", S_MAIN_G, 4, 7, 1'b0);
        serve("side_at_min", 1'b0, 99);
        run("main_g_after_side", S_MAIN_G, 1, 7, 1'b0);
        cyc("main_g_after_side", S_MAIN_G, 7, 1'b0);

        ped_req = 1'b1;
        cyc("ped_pulse", S_MAIN_G, 7, 1'b0);
        ped_req = 1'b0;
        serve("ped_walk", 1'b1, 3);
        run("ped_repeat_main", S_MAIN_G, 1, 7, 1'b0);
        serve("ped_repeat_walk", 1'b1, 99);
        run("main_g_after_ped", S_MAIN_G, 1, 7, 1'b0);
        repeat (3) cyc("main_g_after_ped", S_MAIN_G, 7, 1'b0);

        side_req = 1'b1;
        serve("ped_on_entry", 1'b1, 0);
        run("no_extra_side", S_MAIN_G, 1, 7, 1'b0);
        repeat (5) cyc("no_extra_side", S_MAIN_G, 7, 1'b0);

        side_req = 1'b1;
        cyc("flash_main_y", S_MAIN_Y, 0, 1'b0);
        side_req = 1'b0;
        flash_en = 1'b1;
        run("flash_main_y", S_MAIN_Y, 1, 2, 1'b0);
        run("flash_ar_b", S_AR_B, 0, 1, 1'b0);
        for (int h = 0; h < 3; h++) begin
            for (int i = 0; i < 4; i++) begin
                ped_req = (h == 1 && i == 1);
                cycl("flash_blink", S_FLASH, i, 1'b0, (h % 2 == 0) ? {YEL, RED} : {DARK, DARK});
            end
        end
        ped_req  = 1'b0;
        flash_en = 1'b0;
        run("flash_exit", S_AR_A, 0, 1, 1'b0);
        run("flash_exit_main", S_MAIN_G, 0, 7, 1'b0);
        serve("ped_after_flash", 1'b1, 99);
        run("main_g_after_flash", S_MAIN_G, 1, 7, 1'b0);
        flash_en = 1'b1;
        repeat (3) cyc("flash_ignored_main_g", S_MAIN_G, 7, 1'b0);
        flash_en = 1'b0;

        ped_req = 1'b1;
        cyc("pre_reset", S_MAIN_G, 7, 1'b0);
        ped_req = 1'b0;
        run("pre_reset", S_MAIN_Y, 0, 2, 1'b0);
        run("pre_reset", S_AR_B, 0, 1, 1'b0);
        run("pre_reset_walk", S_SIDE_G, 0, 2, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        push_exp("reset_mid_side_g", S_AR_A, 0, 1'b0, {RED, RED});
        pop_check();
        @(negedge clk);
        push_exp("reset_held", S_AR_A, 0, 1'b0, {RED, RED});
        pop_check();
        rst      = 1'b1;
        flash_en = 1'b1;
        cyc("reset_release", S_AR_A, 1, 1'b0);
        cycl("ar_a_to_flash", S_FLASH, 0, 1'b0, {YEL, RED});
        flash_en = 1'b0;
        run("flash_to_ar_a", S_AR_A, 0, 1, 1'b0);
        run("main_g_post_reset", S_MAIN_G, 0, 7, 1'b0);
        repeat (3) cyc("main_g_post_reset", S_MAIN_G, 7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
